// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and receiver: the FSM
// state encoding, 8N1 frame constants and the clocks-per-symbol helper.
package uart_pkg;

    // FSM state encoding, kept as plain constants for legacy compatibility
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    // 8N1 frame: one start bit, eight data bits, one stop bit
    localparam int   FRAME_BITS = 10;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;

    // Number of CLK cycles each symbol is held on the line
    function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Symbol timer: counts 0..SYMBOL_EDGE_TIME-1 while enabled and pulses tick
// in the cycle the terminal count is reached, wrapping back to zero.
module uart_baud_counter
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic CLK,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int SYMBOL_EDGE_TIME = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
    localparam int CNT_W            = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(SYMBOL_EDGE_TIME - 1);

    logic [CNT_W-1:0] sym_cnt;

    assign tick = enable && (sym_cnt == LAST_COUNT);

    // Symbol counter: clear restarts the symbol, tick wraps it
    always_ff @(posedge CLK) begin
        if (reset || clear) begin
            sym_cnt <= '0;
        end else if (enable) begin
            sym_cnt <= tick ? '0 : sym_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmit path: accepts a byte over a ready/valid handshake and
// shifts it out LSB first as an 8N1 frame on SerialOut (idle high).
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic [7:0] DataIn,
    input  logic       DataInValid,
    output logic       DataInReady,
    output logic       SerialOut
);

    localparam int SYMBOL_EDGE_TIME = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);

    generate
        if (SYMBOL_EDGE_TIME < 2) begin : g_bad_baud
            $error("uart_transmitter: CLOCK_FREQ/BAUD_RATE must be at least 2");
        end
    endgenerate

    logic [0:0]            state;
    logic [3:0]            bit_cnt;
    logic [FRAME_BITS-1:0] shift;
    logic                  handshake;
    logic                  sym_tick;
    logic                  last_bit;

    assign handshake = DataInValid && DataInReady;
    assign last_bit  = (bit_cnt == 4'(FRAME_BITS - 1));

    // The shift register doubles as the line state: bit 0 drives the pin, so
    // the output is a flop and idles at all-ones between frames.
    assign SerialOut = shift[0];

    uart_baud_counter #(
        .CLOCK_FREQ (CLOCK_FREQ),
        .BAUD_RATE  (BAUD_RATE)
    ) u_baud_counter (
        .CLK    (CLK),
        .reset  (reset),
        .clear  (handshake),
        .enable (state == ST_SEND),
        .tick   (sym_tick)
    );

    // Frame sequencing: IDLE accepts a byte, SEND counts the ten symbols
    always_ff @(posedge CLK) begin
        if (reset) begin
            state       <= ST_IDLE;
            DataInReady <= 1'b1;
            bit_cnt     <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (handshake) begin
                        state       <= ST_SEND;
                        DataInReady <= 1'b0;
                        bit_cnt     <= 4'd0;
                    end
                end
                ST_SEND: begin
                    if (sym_tick) begin
                        if (last_bit) begin
                            state       <= ST_IDLE;
                            DataInReady <= 1'b1;
                            bit_cnt     <= 4'd0;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    DataInReady <= 1'b1;
                    bit_cnt     <= 4'd0;
                end
            endcase
        end
    end

    // Frame shifter: load on handshake, shift in stop-level ones each symbol
    always_ff @(posedge CLK) begin
        if (reset) begin
            shift <= '1;
        end else if (handshake) begin
            shift <= {STOP_BIT, DataIn, START_BIT};
        end else if (sym_tick) begin
            shift <= {STOP_BIT, shift[FRAME_BITS-1:1]};
        end
    end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
Serial transmit side of the CPU's UART link. Accepts one byte at a time from the datapath's UART store path via a ready/valid handshake (DataIn, DataInValid, DataInReady), then shifts it out as an 8N1 frame on SerialOut. It is the consumer end of the interface the datapath drives when executing a store to the UART transmit address. It sits between the datapath and the board's FPGA_SERIAL_TX pin.

Parameters:
CLOCK_FREQ, 50_000_000, CLK frequency in Hz
BAUD_RATE, 115_200, line rate in bits/s; SYMBOL_EDGE_TIME = CLOCK_FREQ/BAUD_RATE (integer divide), must be >= 2 (elaboration-time check)

Ports:
CLK  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high reset
DataIn  input  8  byte to transmit, sampled only on handshake cycle
DataInValid  input  1  datapath has a byte for the transmitter
DataInReady  output  1  transmitter can accept a byte this cycle
SerialOut  output  1  serial line, idle high, registered

Behaviour:
- One clock (CLK); reset is synchronous and active-high. All outputs registered.
- Reset: on a CLK edge with reset=1 -> state IDLE, SerialOut=1, DataInReady=1, bit counter=0, symbol counter=0. Reset mid-frame aborts the frame; SerialOut=1 from the next cycle; the partial byte is discarded.
- Handshake: transfer occurs on a CLK edge where DataInValid && DataInReady. DataIn is captured into a 10-bit shift register {1'b1, DataIn, 1'b0} on that edge. DataIn/DataInValid are don't-care in all other cycles.
- FSM states:
  - IDLE: DataInReady=1, SerialOut=1. On handshake -> SEND.
  - SEND: DataInReady=0. SerialOut = shift[0]. Each bit is held for exactly SYMBOL_EDGE_TIME cycles. The symbol counter runs 0..SYMBOL_EDGE_TIME-1. At the terminal count, shift right by 1, bit counter +1, symbol counter wraps to 0. After bit 9 (the stop bit) completes its full SYMBOL_EDGE_TIME cycles -> IDLE.
- Frame: start bit 0, then DataIn[0]..DataIn[7] (LSB first), then stop bit 1. The active frame is exactly 10*SYMBOL_EDGE_TIME cycles.
- Latency: the start bit appears on SerialOut in the cycle after the handshake edge.
- Back-to-back: if DataInValid is held high, the next handshake happens in the first IDLE cycle after the stop bit. The line is therefore high for SYMBOL_EDGE_TIME+1 cycles between frames (minimum inter-frame gap). Throughput is one byte per 10*SYMBOL_EDGE_TIME+1 cycles.
- Simultaneous reset and DataInValid: reset wins; no byte is accepted.
- DataInValid high while DataInReady=0: ignored, with no side effects. The datapath is responsible for polling DataInReady before storing.
- Symbol counter width = clog2(SYMBOL_EDGE_TIME). Bit counter width = 4, range 0..9, never exceeds 9.

Decomposition:
- Shared package uart_pkg holds:
  - the FSM state encoding (IDLE, SEND)
  - constants FRAME_BITS=10, START_BIT=0, STOP_BIT=1
  - a SYMBOL_EDGE_TIME helper function
  
  The uart_receiver uses the same package.
- One sub-module is natural: uart_baud_counter (parameters CLOCK_FREQ, BAUD_RATE; inputs CLK, reset, clear, enable; output tick, pulsed on the terminal count). It is shared with uart_receiver.

Test Plan:
- Reset idle: hold reset 5 cycles, release -> SerialOut=1, DataInReady=1 and unchanged for 100 cycles with DataInValid=0.
- Single byte (CLOCK_FREQ=100, BAUD_RATE=10, so 10 cycles/bit): handshake DataIn=8'hA5 -> next cycle SerialOut=0 for 10 cycles, then bits 1,0,1,0,0,1,0,1 at 10 cycles each, then 1 for 10 cycles. DataInReady=0 for exactly 100 cycles, then 1.
- Back-to-back: DataInValid held high with 8'h00 then 8'hFF -> two frames. The gap between the last data bit of frame 1 and the start bit of frame 2 is exactly 11 high cycles. Exactly 2 handshakes occur.
- Ignore while busy: assert DataInValid with DataIn=8'h3C at cycle 40 of an 8'h55 frame -> the frame remains 8'h55. No second frame starts until Valid is reasserted while Ready=1.
- Reset mid-frame: assert reset at cycle 35 of a frame -> SerialOut=1 and DataInReady=1 from the next cycle. A new handshake with 8'h81 yields a complete, correct frame.
- Random stress: 200 random bytes with random Valid gaps, checked by a behavioural 8N1 receiver model -> every byte received in order, and no frame shorter than 100 cycles.
